keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Parametrised matrix-keypad scanner; successor to the fixed 4x4 Pmod keypad controller.
- Drives columns one at a time (active-low), samples synchronised rows and debounces whole scan frames.
- Detects single-key press and release, and queues press/release events in a small FIFO with a valid/ready handshake for the CPU I/O bus.
- Also gives a level view of the currently held key.

Parameters:
- NUM_ROWS, 4, number of sensed rows (>=1)
- NUM_COLS, 4, number of driven columns (>=2)
- SCAN_DIV, 50000, CLK cycles each column is driven (dwell); >=4
- DEBOUNCE_FRAMES, 3, consecutive identical frames needed to confirm a press or release; >=1
- FIFO_DEPTH, 4, event queue depth; power of 2, >=2
- CODE_W, $clog2(NUM_ROWS*NUM_COLS), key code width (derived, not overridden)

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- ROWS  in  NUM_ROWS  row sense lines, pulled up; 0 = key closed in the driven column
- COLS  out  NUM_COLS  column drives; exactly one bit low at all times
- EVT_VALID  out  1  FIFO not empty
- EVT_READY  in  1  consumer accepts head event
- EVT_CODE  out  CODE_W  head event key code = row*NUM_COLS + col
- EVT_RELEASE  out  1  head event type: 0 = press, 1 = release
- KEY_HELD  out  1  a debounced key is held (states HELD, REL_DB)
- HELD_CODE  out  CODE_W  code of held key; 0 when KEY_HELD=0
- OVERFLOW  out  1  sticky: event dropped because FIFO was full
- OVF_CLR  in  1  clears OVERFLOW

Behaviour:
- Reset (async, immediate):
  - COLS = all ones except bit 0 low; column index 0; dwell counter 0.
  - FSM in IDLE, candidate 0, frame count 0, FIFO empty.
  - EVT_VALID=0, EVT_CODE=0, EVT_RELEASE=0, KEY_HELD=0, HELD_CODE=0, OVERFLOW=0.
  - Synchroniser flops cleared to all ones.
  - Reset mid-scan or mid-debounce discards all partial state; no event is produced.
- ROWS pass through a 2-flop synchroniser before use.
- Scan:
  - Dwell counter runs 0..SCAN_DIV-1.
  - When the counter is SCAN_DIV-1, the synchronised rows are sampled for the current column; on the next edge the column advances (wraps NUM_COLS-1 -> 0) and COLS rotates.
  - One frame = NUM_COLS*SCAN_DIV cycles.
- Frame classification, computed on the sample of the last column, registered as a one-cycle frame_done pulse:
  - NONE: no closures.
  - SINGLE(k): exactly one closure, code k.
  - MULTI: more than one closure, including two rows in one column.
- Debounce FSM, updates only on frame_done. cnt = consecutive matching frames.
  - IDLE:
    - SINGLE(k): cand=k, cnt=1. If DEBOUNCE_FRAMES=1, go to HELD and push press; otherwise go to PRESS_DB.
    - NONE or MULTI: stay in IDLE.
  - PRESS_DB:
    - SINGLE(cand): cnt++. When cnt reaches DEBOUNCE_FRAMES, go to HELD and push press(cand).
    - SINGLE(j), j!=cand: cand=j, cnt=1, stay.
    - NONE or MULTI: go to IDLE, no event.
  - HELD:
    - SINGLE(cand) or MULTI: stay (rollover suppression).
    - NONE or SINGLE(j!=cand): cnt=1. If DEBOUNCE_FRAMES=1, go to IDLE and push release(cand); otherwise go to REL_DB.
  - REL_DB:
    - SINGLE(cand): back to HELD, no event.
    - Any other frame: cnt++. When cnt reaches DEBOUNCE_FRAMES, go to IDLE and push release(cand).
  - A key still down after a release is detected afresh from IDLE on following frames.
- HELD_CODE = cand while KEY_HELD, else 0.
- FIFO:
  - Push happens on the FSM transition edge; EVT_VALID rises the following cycle (registered outputs).
  - Pop on EVT_VALID && EVT_READY; EVT_CODE/EVT_RELEASE are the head entry.
  - Head is stable while EVT_VALID=1 and EVT_READY=0.
  - Push when full with no pop: event dropped, OVERFLOW set.
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Push into an empty FIFO is never bypassed to the output in the same cycle.
  - OVF_CLR clears OVERFLOW; a set in the same cycle wins.
- Scan and debounce never stall on FIFO state.

Test Plan (4x4, SCAN_DIV=4, DEBOUNCE_FRAMES=3, FIFO_DEPTH=4; frame = 16 cycles):
- Reset, no key -> COLS cycles 1110,1101,1011,0111 every 4 CLK; EVT_VALID stays 0; KEY_HELD=0.
- Hold row 2 low while col 1 driven for 5 frames, EVT_READY=1 -> single press event, code 9, RELEASE=0, 1 cycle after the 3rd frame_done; KEY_HELD=1, HELD_CODE=9. Release for 3 frames -> release event, code 9; HELD_CODE back to 0.
- Key 5 closed for 2 frames, then open -> no event; FSM back to IDLE.
- Hold key 0, then add key 15 (MULTI) for 4 frames, then release both -> press(0) and release(0) only; no event for 15.
- EVT_READY=0, perform 3 press/release pairs (6 events) -> after 4 pushes FIFO full; 5th push sets OVERFLOW; EVT_VALID stays 1 with head = press(first code); pulsing OVF_CLR clears OVERFLOW.
- Assert RESET during PRESS_DB with 2 events queued -> all outputs return to reset values immediately; no event after RESET drops until a fresh 3-frame press.

Source files
------------

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: rotates an active-low column drive, synchronises the
// row senses, classifies each full scan frame, debounces single-key presses and
// releases over whole frames, and queues press/release events in a small FIFO.
module keypad_scanner #(
  parameter int NUM_ROWS        = 4,
  parameter int NUM_COLS        = 4,
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int FIFO_DEPTH      = 4,
  parameter int CODE_W          = $clog2(NUM_ROWS * NUM_COLS)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NUM_ROWS-1:0] ROWS,
  output logic [NUM_COLS-1:0] COLS,
  output logic                EVT_VALID,
  input  logic                EVT_READY,
  output logic [CODE_W-1:0]   EVT_CODE,
  output logic                EVT_RELEASE,
  output logic                KEY_HELD,
  output logic [CODE_W-1:0]   HELD_CODE,
  output logic                OVERFLOW,
  input  logic                OVF_CLR
);

  localparam int COL_W = $clog2(NUM_COLS);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [NUM_COLS-1:0] COLS_RST = ~(NUM_COLS'(1));
  localparam logic [DIV_W-1:0]    DWELL_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0]    COL_LAST   = COL_W'(NUM_COLS - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_DONE   = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [AW:0]         FULL_CNT   = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {FR_NONE, FR_SINGLE, FR_MULTI} frame_e;
  typedef enum logic [1:0] {ST_IDLE, ST_PRESS_DB, ST_HELD, ST_REL_DB} state_e;

  logic [NUM_ROWS-1:0] rows_meta_q, rows_sync_q;
  logic [DIV_W-1:0]    dwell_q, dwell_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [NUM_COLS-1:0] cols_q, cols_d;
  logic                sample;
  frame_e              kind, acc_kind_q, acc_kind_d, frame_kind_q, frame_kind_d;
  logic [CODE_W-1:0]   code, acc_code_q, acc_code_d, frame_code_q, frame_code_d;
  logic                frame_done_q, frame_done_d;
  state_e              state_q, state_d;
  logic [CODE_W-1:0]   cand_q, cand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                single, match, push, push_rel;
  logic [CODE_W-1:0]   push_code;
  logic [CODE_W:0]     mem_q [FIFO_DEPTH];
  logic [CODE_W:0]     mem_d [FIFO_DEPTH];
  logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]         count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                pop, full, do_push;

  // Two-flop row synchroniser; idle level is all ones (pull-ups).
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rows_meta_q <= '1;
      rows_sync_q <= '1;
    end else begin
      rows_meta_q <= ROWS;
      rows_sync_q <= rows_meta_q;
    end
  end

  // Column dwell timing, column rotation and per-frame closure accumulation.
  always_comb begin
    sample  = (dwell_q == DWELL_LAST);
    dwell_d = dwell_q + DIV_W'(1);
    col_d   = col_q;
    cols_d  = cols_q;
    if (sample) begin
      dwell_d = '0;
      col_d   = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
      cols_d  = {cols_q[NUM_COLS-2:0], cols_q[NUM_COLS-1]};
    end

    // Column 0 starts a fresh frame; otherwise extend what earlier columns saw.
    kind = (col_q == '0) ? FR_NONE : acc_kind_q;
    code = (col_q == '0) ? '0 : acc_code_q;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (!rows_sync_q[r]) begin
        if (kind == FR_NONE) begin
          kind = FR_SINGLE;
          code = CODE_W'(r * NUM_COLS + 32'(col_q));
        end else begin
          kind = FR_MULTI;
        end
      end
    end

    acc_kind_d   = acc_kind_q;
    acc_code_d   = acc_code_q;
    frame_done_d = 1'b0;
    frame_kind_d = frame_kind_q;
    frame_code_d = frame_code_q;
    if (sample) begin
      if (col_q == COL_LAST) begin
        frame_done_d = 1'b1;
        frame_kind_d = kind;
        frame_code_d = code;
      end else begin
        acc_kind_d = kind;
        acc_code_d = code;
      end
    end
  end

  // Scan and frame-classification registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dwell_q      <= '0;
      col_q        <= '0;
      cols_q       <= COLS_RST;
      acc_kind_q   <= FR_NONE;
      acc_code_q   <= '0;
      frame_done_q <= 1'b0;
      frame_kind_q <= FR_NONE;
      frame_code_q <= '0;
    end else begin
      dwell_q      <= dwell_d;
      col_q        <= col_d;
      cols_q       <= cols_d;
      acc_kind_q   <= acc_kind_d;
      acc_code_q   <= acc_code_d;
      frame_done_q <= frame_done_d;
      frame_kind_q <= frame_kind_d;
      frame_code_q <= frame_code_d;
    end
  end

  // Debounce next-state and event generation, evaluated only on frame_done.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_rel  = 1'b0;
    push_code = cand_q;
    single    = (frame_kind_q == FR_SINGLE);
    match     = single && (frame_code_q == cand_q);
    if (frame_done_q) begin
      unique case (state_q)
        ST_IDLE: begin
          if (single) begin
            cand_d    = frame_code_q;
            cnt_d     = CNT_ONE;
            push_code = frame_code_q;
            if (DEBOUNCE_FRAMES == 1) begin
              state_d = ST_HELD;
              push    = 1'b1;
            end else begin
              state_d = ST_PRESS_DB;
            end
          end
        end
        ST_PRESS_DB: begin
          if (match) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_d == CNT_DONE) begin
              state_d = ST_HELD;
              push    = 1'b1;
            end
          end else if (single) begin
            cand_d = frame_code_q;
            cnt_d  = CNT_ONE;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_HELD: begin
          // MULTI is ignored while held so rollover cannot steal the key.
          if (!match && (frame_kind_q != FR_MULTI)) begin
            cnt_d = CNT_ONE;
            if (DEBOUNCE_FRAMES == 1) begin
              state_d  = ST_IDLE;
              push     = 1'b1;
              push_rel = 1'b1;
              cnt_d    = '0;
            end else begin
              state_d = ST_REL_DB;
            end
          end
        end
        ST_REL_DB: begin
          if (match) begin
            state_d = ST_HELD;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_d == CNT_DONE) begin
              state_d  = ST_IDLE;
              push     = 1'b1;
              push_rel = 1'b1;
              cnt_d    = '0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Debounce state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Event FIFO bookkeeping; a pop frees the slot a same-cycle push needs.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    pop     = (count_q != '0) && EVT_READY;
    full    = (count_q == FULL_CNT);
    do_push = push && (!full || pop);
    if (do_push) begin
      mem_d[wr_q] = {push_rel, push_code};
      wr_d        = wr_q + AW'(1);
    end
    if (pop) begin
      rd_d = rd_q + AW'(1);
    end
    if (do_push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop && !do_push) begin
      count_d = count_q - (AW+1)'(1);
    end
    ovf_d = ovf_q;
    if (OVF_CLR) begin
      ovf_d = 1'b0;
    end
    if (push && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  // FIFO storage, pointers and sticky overflow flag.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign COLS                    = cols_q;
  assign EVT_VALID               = (count_q != '0);
  assign {EVT_RELEASE, EVT_CODE} = mem_q[rd_q];
  assign KEY_HELD                = (state_q == ST_HELD) || (state_q == ST_REL_DB);
  assign HELD_CODE               = KEY_HELD ? cand_q : '0;
  assign OVERFLOW                = ovf_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner at 4x4, SCAN_DIV=4, DEBOUNCE_FRAMES=3,
// FIFO_DEPTH=4. Edge numbers count posedges after reset release; frame n ends
// with frame_done after edge 16n and the debounce FSM acts on edge 16n+1.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_code;
  logic        evt_release;
  logic        key_held;
  logic [3:0]  held_code;
  logic        overflow;
  logic        ovf_clr;
  logic [15:0] keys;

  int          n_cmp  = 0;
  int          n_bad  = 0;
  int          edge_n = 0;
  logic [4:0]  ev_log [$];

  keypad_scanner #(
    .NUM_ROWS       (4),
    .NUM_COLS       (4),
    .SCAN_DIV       (4),
    .DEBOUNCE_FRAMES(3),
    .FIFO_DEPTH     (4)
  ) dut (
    .CLK        (clk),
    .RESET      (rst),
    .ROWS       (rows),
    .COLS       (cols),
    .EVT_VALID  (evt_valid),
    .EVT_READY  (evt_ready),
    .EVT_CODE   (evt_code),
    .EVT_RELEASE(evt_release),
    .KEY_HELD   (key_held),
    .HELD_CODE  (held_code),
    .OVERFLOW   (overflow),
    .OVF_CLR    (ovf_clr)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a closed key pulls its row low while its column is driven.
  always_comb begin
    rows = '1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
      end
    end
  end

  // Log every accepted event as {release, code}.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) ev_log.push_back({evt_release, evt_code});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic adv_to(input int target);
    while (edge_n < target) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cols"}, 32'(cols), 32'hE);
    check_eq({tag, "_valid"}, 32'(evt_valid), 32'h0);
    check_eq({tag, "_code"}, 32'(evt_code), 32'h0);
    check_eq({tag, "_rel"}, 32'(evt_release), 32'h0);
    check_eq({tag, "_held"}, 32'(key_held), 32'h0);
    check_eq({tag, "_hcode"}, 32'(held_code), 32'h0);
    check_eq({tag, "_ovf"}, 32'(overflow), 32'h0);
  endtask

  task automatic check_event(input string tag, input logic [3:0] code, input logic rel);
    check_eq({tag, "_valid"}, 32'(evt_valid), 32'h1);
    check_eq({tag, "_code"}, 32'(evt_code), 32'(code));
    check_eq({tag, "_rel"}, 32'(evt_release), 32'(rel));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    keys      = '0;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    edge_n = 0;
    #1;
    check_reset_outputs("rst0");

    // Column rotation every 4 clocks, no keys.
    adv_to(3);  check_eq("cols_e3", 32'(cols), 32'hE);
    adv_to(4);  check_eq("cols_e4", 32'(cols), 32'hD);
    adv_to(8);  check_eq("cols_e8", 32'(cols), 32'hB);
    adv_to(12); check_eq("cols_e12", 32'(cols), 32'h7);
    adv_to(16); check_eq("cols_e16", 32'(cols), 32'hE);

    // Key 9 (row 2, col 1): frames 3-7 held, frames 8-10 released.
    adv_to(32);
    check_eq("idle_valid", 32'(evt_valid), 32'h0);
    check_eq("idle_held", 32'(key_held), 32'h0);
    keys = 16'h0200;
    adv_to(80);
    check_eq("k9_pre_valid", 32'(evt_valid), 32'h0);
    check_eq("k9_pre_held", 32'(key_held), 32'h0);
    adv_to(81);
    check_event("k9_press", 4'd9, 1'b0);
    check_eq("k9_held", 32'(key_held), 32'h1);
    check_eq("k9_hcode", 32'(held_code), 32'h9);
    adv_to(82);
    check_eq("k9_popped", 32'(evt_valid), 32'h0);
    adv_to(112);
    check_eq("k9_still_held", 32'(key_held), 32'h1);
    keys = '0;
    adv_to(160);
    check_eq("k9_reldb_held", 32'(key_held), 32'h1);
    check_eq("k9_reldb_valid", 32'(evt_valid), 32'h0);
    adv_to(161);
    check_event("k9_release", 4'd9, 1'b1);
    check_eq("k9_rel_held", 32'(key_held), 32'h0);
    check_eq("k9_rel_hcode", 32'(held_code), 32'h0);

    // Key 5 for only two frames: no event.
    keys = 16'h0020;
    adv_to(192);
    keys = '0;
    adv_to(208);
    check_eq("k5_held", 32'(key_held), 32'h0);
    check_eq("k5_ev_n", ev_log.size(), 32'd2);

    // Key 0 held, key 15 added for four frames, then both released.
    keys = 16'h0001;
    adv_to(256);
    check_eq("k0_pre_held", 32'(key_held), 32'h0);
    keys = 16'h8001;
    adv_to(257);
    check_event("k0_press", 4'd0, 1'b0);
    check_eq("k0_held", 32'(key_held), 32'h1);
    adv_to(320);
    check_eq("multi_held", 32'(key_held), 32'h1);
    check_eq("multi_hcode", 32'(held_code), 32'h0);
    check_eq("multi_ev_n", ev_log.size(), 32'd3);
    keys = '0;
    adv_to(368);
    check_eq("k0_reldb_held", 32'(key_held), 32'h1);
    keys = 16'h0002;
    adv_to(369);
    check_event("k0_release", 4'd0, 1'b1);
    check_eq("k0_rel_held", 32'(key_held), 32'h0);
    adv_to(370);
    check_eq("k0_ev_n", ev_log.size(), 32'd4);
    evt_ready = 1'b0;

    // Three press/release pairs (keys 1, 2, 3) with the consumer stalled.
    adv_to(416); keys = '0;
    adv_to(418);
    check_event("fifo_head1", 4'd1, 1'b0);
    adv_to(464); keys = 16'h0004;
    adv_to(512); keys = '0;
    adv_to(560);
    check_eq("fifo_ovf_pre", 32'(overflow), 32'h0);
    keys = 16'h0008;
    adv_to(561);
    check_eq("fifo_full_ovf", 32'(overflow), 32'h0);
    adv_to(608); keys = '0;
    adv_to(609);
    check_eq("fifo_ovf_set", 32'(overflow), 32'h1);
    check_event("fifo_head_ovf", 4'd1, 1'b0);
    adv_to(620); ovf_clr = 1'b1;
    adv_to(621);
    check_eq("ovf_clr", 32'(overflow), 32'h0);
    ovf_clr = 1'b0;
    adv_to(656); ovf_clr = 1'b1;
    adv_to(657);
    check_eq("ovf_set_wins", 32'(overflow), 32'h1);
    ovf_clr = 1'b0;
    adv_to(660); ovf_clr = 1'b1;
    adv_to(661);
    check_eq("ovf_clr2", 32'(overflow), 32'h0);
    ovf_clr = 1'b0;
    check_event("fifo_head_stable", 4'd1, 1'b0);
    adv_to(670); evt_ready = 1'b1;
    adv_to(680);
    evt_ready = 1'b0;
    check_eq("drain_valid", 32'(evt_valid), 32'h0);
    check_eq("drain_ev_n", ev_log.size(), 32'd8);
    check_eq("ev0", 32'(ev_log[0]), 32'h09);
    check_eq("ev1", 32'(ev_log[1]), 32'h19);
    check_eq("ev2", 32'(ev_log[2]), 32'h00);
    check_eq("ev3", 32'(ev_log[3]), 32'h10);
    check_eq("ev4", 32'(ev_log[4]), 32'h01);
    check_eq("ev5", 32'(ev_log[5]), 32'h11);
    check_eq("ev6", 32'(ev_log[6]), 32'h02);
    check_eq("ev7", 32'(ev_log[7]), 32'h12);

    // Queue press/release of key 4, then reset while key 7 is mid-debounce.
    adv_to(688); keys = 16'h0010;
    adv_to(736); keys = '0;
    adv_to(784); keys = 16'h0080;
    adv_to(818);
    check_event("pre_rst_head", 4'd4, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst1");
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    edge_n = 0;
    adv_to(17);
    check_eq("post_rst_v17", 32'(evt_valid), 32'h0);
    adv_to(33);
    check_eq("post_rst_v33", 32'(evt_valid), 32'h0);
    adv_to(48);
    check_eq("post_rst_v48", 32'(evt_valid), 32'h0);
    check_eq("post_rst_held48", 32'(key_held), 32'h0);
    adv_to(49);
    check_event("k7_press", 4'd7, 1'b0);
    check_eq("k7_hcode", 32'(held_code), 32'h7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
